sdram_autorefresh: RTL

- Stage directly downstream of the SDRAM power-up/initialisation block. It starts once that block raises init_end_flag.
- Generates periodic refresh requests to the SDRAM command arbiter.
- On grant, drives the precharge-all plus auto-refresh command sequence with tRP/tRC spacing, then signals completion.
- Its command, bank and address outputs are muxed by the arbiter onto the SDRAM pins.

---
 rtl/sdram_autorefresh_if.sv | 24 ++
 rtl/sdram_autorefresh.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sdram_autorefresh_if.sv
// Refresh-block <-> command-arbiter connection: grant/request handshake plus
// the SDRAM command, bank and address bus that the arbiter muxes onto the pins.
interface sdram_autorefresh_if;
  logic        ref_en;
  logic        ref_req;
  logic        ref_end;
  logic        ref_busy;
  logic        ref_miss;
  logic [3:0]  cmd_reg;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  // Arbiter side: grants and observes the refresh block
  modport master (
    output ref_en,
    input  ref_req, ref_end, ref_busy, ref_miss, cmd_reg, sdram_ba, sdram_addr
  );

  // Refresh block side
  modport slave (
    input  ref_en,
    output ref_req, ref_end, ref_busy, ref_miss, cmd_reg, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_autorefresh.sv
// SDRAM auto-refresh stage: periodic request generation and, on grant, the
// PRECHARGE-all + REF_BURST x AUTO REFRESH sequence with tRP/tRC spacing.
module sdram_autorefresh #(
  parameter int unsigned REF_PERIOD = 750,
  parameter int unsigned TRP_CLK    = 2,
  parameter int unsigned TRC_CLK    = 7,
  parameter int unsigned REF_BURST  = 2
) (
  input  logic                 sysclk_100M,
  input  logic                 rst,
  input  logic                 init_end_flag,
  sdram_autorefresh_if.slave   bus
);

  localparam int unsigned CNT_W    = $clog2(REF_PERIOD);
  localparam int unsigned WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned BURST_W  = $clog2(REF_BURST + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRECH = 3'd1,
    TRP   = 3'd2,
    AREF  = 3'd3,
    TRC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     int_cnt;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_cnt_nxt;
  logic [3:0]           cmd_c;
  logic                 end_c;
  logic                 busy_c;
  logic                 expire_c;
  logic                 grant_c;

  assign expire_c = init_end_flag && (int_cnt == CNT_W'(REF_PERIOD - 1));
  assign grant_c  = (state == IDLE) && bus.ref_req && bus.ref_en && init_end_flag;

  assign bus.sdram_ba   = 2'b00;
  assign bus.sdram_addr = 13'h0400;

  // Refresh interval counter, parked at 0 until initialisation has finished
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      int_cnt <= '0;
    end else if (!init_end_flag || expire_c) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + CNT_W'(1);
    end
  end

  // Request and missed-interval tracking; a fresh expiry outranks a grant
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      bus.ref_req  <= 1'b0;
      bus.ref_miss <= 1'b0;
    end else begin
      if (!init_end_flag) begin
        bus.ref_req <= 1'b0;
      end else if (expire_c) begin
        bus.ref_req <= 1'b1;
      end else if (grant_c) begin
        bus.ref_req <= 1'b0;
      end
      if (expire_c && bus.ref_req && !grant_c) begin
        bus.ref_miss <= 1'b1;
      end
    end
  end

  // Sequencer state and its wait/burst counters
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state and per-state command decode
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    burst_cnt_nxt = burst_cnt;
    cmd_c         = CMD_NOP;
    end_c         = 1'b0;
    busy_c        = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (grant_c) begin
          state_nxt = PRECH;
        end
      end
      PRECH: begin
        cmd_c        = CMD_PRE;
        wait_cnt_nxt = '0;
        state_nxt    = TRP;
      end
      TRP: begin
        if (wait_cnt == WAIT_W'(TRP_CLK - 1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = AREF;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      AREF: begin
        cmd_c         = CMD_AREF;
        burst_cnt_nxt = burst_cnt + BURST_W'(1);
        wait_cnt_nxt  = '0;
        state_nxt     = TRC;
      end
      TRC: begin
        if (wait_cnt == WAIT_W'(TRC_CLK - 1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = (burst_cnt < BURST_W'(REF_BURST)) ? AREF : DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      DONE: begin
        end_c         = 1'b1;
        wait_cnt_nxt  = '0;
        burst_cnt_nxt = '0;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        wait_cnt_nxt  = '0;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Registered command and status outputs, one cycle behind the state
  always_ff @(posedge sysclk_100M or posedge rst) begin
    if (rst) begin
      bus.cmd_reg  <= CMD_NOP;
      bus.ref_end  <= 1'b0;
      bus.ref_busy <= 1'b0;
    end else begin
      bus.cmd_reg  <= cmd_c;
      bus.ref_end  <= end_c;
      bus.ref_busy <= busy_c;
    end
  end

endmodule
